// File: rtl/poco_pkg.sv
// Shared types and defaults for the POCO-R fetch queue.
package poco_pkg;

  localparam int unsigned DefaultXlen = 16;
  localparam int unsigned DefaultIlen = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDiscard
  } fetch_state_e;

  typedef struct packed {
    logic [DefaultIlen-1:0] op;
    logic [DefaultXlen-1:0] pc_next;
  } fq_entry_t;

endpackage

// File: rtl/poco_fetch_queue_if.sv
// Memory-side and decode-side signals of the fetch queue.
interface poco_fetch_queue_if import poco_pkg::*; #(
  parameter int unsigned XLEN  = DefaultXlen,
  parameter int unsigned ILEN  = DefaultIlen,
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_valid;
  logic [ILEN-1:0] imem_data;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            id_valid;
  logic [ILEN-1:0] id_op;
  logic [XLEN-1:0] id_pc_next;
  logic            id_ready;
  logic [CW-1:0]   q_count;

  modport master (
    output imem_req, imem_addr, id_valid, id_op, id_pc_next, q_count,
    input  imem_valid, imem_data, redir_valid, redir_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_op, id_pc_next, q_count,
    output imem_valid, imem_data, redir_valid, redir_pc, id_ready
  );

endinterface

// File: rtl/poco_sync_fifo.sv
// Synchronous FIFO with registered head output; the head holds its last value when empty.
module poco_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, after_pop;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             valid_q;

  always_comb begin
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    after_pop = count_q - CW'(pop);
    rdata_d   = rdata_q;
    // Next head comes from storage if anything older remains, else from the incoming word.
    if (after_pop != '0) begin
      rdata_d = mem_q[rd_ptr_d];
    end else if (push) begin
      rdata_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      valid_q  <= (count_d != '0);
    end
  end

  assign rdata = rdata_q;
  assign valid = valid_q;
  assign count = count_q;

endmodule

// File: rtl/poco_fetch_queue.sv
// Instruction fetch stage: sequential requests to a variable-latency memory, ops buffered for
// decode, redirect flushes the queue and drops any in-flight response.
module poco_fetch_queue import poco_pkg::*; #(
  parameter int unsigned    XLEN     = DefaultXlen,
  parameter int unsigned    ILEN     = DefaultIlen,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst_n,
  poco_fetch_queue_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  fetch_state_e         state_q;
  logic [XLEN-1:0]      fetch_pc_q, req_addr_q;
  logic                 push, pop, issue;
  logic [OW-1:0]        occ_next;
  logic [ILEN+XLEN-1:0] fifo_rdata;
  logic                 stray_ok_q;

  always_comb begin
    pop      = bus.id_valid && bus.id_ready && !bus.redir_valid;
    push     = (state_q == StWait) && bus.imem_valid && !bus.redir_valid;
    occ_next = OW'(bus.q_count) + OW'(push) - OW'(pop);
    issue    = rst_n && !bus.redir_valid &&
               ((state_q == StIdle) || ((state_q == StWait) && bus.imem_valid)) &&
               (occ_next < OW'(DEPTH));
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
    end else if (bus.redir_valid) begin
      fetch_pc_q <= bus.redir_pc;
      case (state_q)
        StWait:    state_q <= bus.imem_valid ? StIdle : StDiscard;
        StDiscard: state_q <= bus.imem_valid ? StIdle : StDiscard;
        default:   state_q <= StIdle;
      endcase
    end else if (issue) begin
      fetch_pc_q <= fetch_pc_q + XLEN'(1);
      req_addr_q <= fetch_pc_q;
      state_q    <= StWait;
    end else if ((state_q != StIdle) && bus.imem_valid) begin
      state_q    <= StIdle;
    end
  end

  poco_sync_fifo #(
    .WIDTH(ILEN + XLEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(bus.redir_valid),
    .push (push),
    .wdata({bus.imem_data, req_addr_q + XLEN'(1)}),
    .pop  (pop),
    .rdata(fifo_rdata),
    .valid(bus.id_valid),
    .count(bus.q_count)
  );

  assign bus.id_op      = fifo_rdata[XLEN +: ILEN];
  assign bus.id_pc_next = fifo_rdata[XLEN-1:0];

  // A response to a request cut off by reset may still land before the first new issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stray_ok_q <= 1'b1;
    end else if (issue) begin
      stray_ok_q <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == StIdle) && bus.imem_valid && !stray_ok_q));

endmodule

// File: tb/tb_poco_fetch_queue.sv
// Scoreboard bench for poco_fetch_queue: directed scenarios plus random traffic.
module tb_poco_fetch_queue;
  import poco_pkg::*;

  localparam int unsigned XLEN = 16;
  localparam int unsigned ILEN = 16;
  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] RESET_PC = 16'h0010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  poco_fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

  poco_fetch_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Expected stream: after reset/redirect to P, requests and delivered ops run P, P+1, ...
  fq_entry_t   exp_op_q[$];
  logic [15:0] exp_req_q[$];
  logic [15:0] gen_pc;

  bit          mem_pend = 0;
  logic [15:0] mem_addr;
  int          mem_cnt;
  int          lat = 1;
  bit          stray = 0;
  bit          last_req;
  logic [15:0] last_addr;

  function automatic logic [15:0] op_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  task automatic topup();
    fq_entry_t e;
    while (exp_req_q.size() < 8) begin
      exp_req_q.push_back(gen_pc);
      e.op      = op_of(gen_pc);
      e.pc_next = gen_pc + 16'd1;
      exp_op_q.push_back(e);
      gen_pc = gen_pc + 16'd1;
    end
  endtask

  task automatic restart(input logic [15:0] pc);
    exp_op_q.delete();
    exp_req_q.delete();
    gen_pc = pc;
    topup();
  endtask

  // Drive one cycle's inputs (caller is at the negedge), then record any request.
  task automatic apply(input bit ready, input bit rv, input logic [15:0] rpc);
    bus.id_ready    = ready;
    bus.redir_valid = rv;
    bus.redir_pc    = rpc;
    bus.imem_valid  = 1'b0;
    bus.imem_data   = 16'($urandom);
    if (stray) begin
      bus.imem_valid = 1'b1;
      bus.imem_data  = 16'hBEEF;
      stray = 0;
    end else if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_data  = op_of(mem_addr);
        mem_pend = 0;
      end
    end
    if (rv) restart(rpc);
    #1;
    last_req  = bus.imem_req;
    last_addr = bus.imem_addr;
    if (bus.imem_req) begin
      check("one_outstanding", 32'(mem_pend), 32'(0));
      mem_pend = 1;
      mem_addr = bus.imem_addr;
      mem_cnt  = lat;
    end
    topup();
  endtask

  task automatic cycle(input bit ready, input bit rv, input logic [15:0] rpc);
    @(negedge clk);
    apply(ready, rv, rpc);
  endtask

  // Monitor: pops expected entries whenever the DUT issues or hands an op to decode.
  initial begin : monitor
    fq_entry_t   e;
    logic [15:0] a;
    bit          pop;
    int          stall;
    stall = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        pop = bus.id_valid && bus.id_ready && !bus.redir_valid;
        check("valid_vs_count", 32'(bus.id_valid), 32'(bus.q_count != 0));
        check("count_bound", 32'(32'(bus.q_count) <= DEPTH), 32'(1));
        if (32'(bus.q_count) == DEPTH && !pop) check("no_issue_full", 32'(bus.imem_req), 32'(0));
        if (bus.imem_req) begin
          if (exp_req_q.size() == 0) fail_now("req_unexpected");
          else begin
            a = exp_req_q.pop_front();
            check("req_addr", 32'(bus.imem_addr), 32'(a));
          end
        end
        if (pop) begin
          if (exp_op_q.size() == 0) fail_now("pop_unexpected");
          else begin
            e = exp_op_q.pop_front();
            check("id_op", 32'(bus.id_op), 32'(e.op));
            check("id_pc_next", 32'(bus.id_pc_next), 32'(e.pc_next));
          end
        end
        if (bus.imem_req || pop || bus.redir_valid) stall = 0;
        else if (bus.id_ready) stall++;
        if (stall > 40) begin
          fail_now("no_progress");
          stall = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit found;
    bus.id_ready = 0; bus.redir_valid = 0; bus.redir_pc = '0;
    bus.imem_valid = 0; bus.imem_data = '0;
    restart(RESET_PC);
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(bus.imem_req), 32'(0));
    check("rst_valid", 32'(bus.id_valid), 32'(0));
    check("rst_count", 32'(bus.q_count), 32'(0));
    check("rst_op", 32'(bus.id_op), 32'(0));
    check("rst_pcn", 32'(bus.id_pc_next), 32'(0));

    // Streaming with a 1-cycle memory.
    lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 0, 0);
    check("s_req0", 32'(last_req), 32'(1));
    check("s_addr0", 32'(last_addr), 32'h10);
    cycle(1, 0, 0);
    check("s_addr1", 32'(last_addr), 32'h11);
    cycle(1, 0, 0);
    check("s_addr2", 32'(last_addr), 32'h12);
    check("s_v0", 32'(bus.id_valid), 32'(1));
    check("s_pcn0", 32'(bus.id_pc_next), 32'h11);
    cycle(1, 0, 0);
    check("s_pcn1", 32'(bus.id_pc_next), 32'h12);
    cycle(1, 0, 0);
    check("s_pcn2", 32'(bus.id_pc_next), 32'h13);

    // Back-pressure until full, then resume.
    repeat (8) cycle(0, 0, 0);
    check("full_count", 32'(bus.q_count), 32'(DEPTH));
    check("full_noreq", 32'(last_req), 32'(0));
    cycle(1, 0, 0);
    check("resume_req", 32'(last_req), 32'(1));
    cycle(1, 0, 0);
    check("resume_cnt", 32'(bus.q_count), 32'(3));
    check("resume_req2", 32'(last_req), 32'(1));

    // Redirect while a 3-cycle request is outstanding.
    lat = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1, 0, 0);
      found = last_req;
    end
    check("disc_found", 32'(found), 32'(1));
    cycle(1, 1, 16'h0200);
    check("disc_r_noreq", 32'(last_req), 32'(0));
    cycle(1, 0, 0);
    check("disc_cnt1", 32'(bus.q_count), 32'(0));
    check("disc_noreq1", 32'(last_req), 32'(0));
    cycle(1, 0, 0);
    check("disc_cnt2", 32'(bus.q_count), 32'(0));
    check("disc_noreq2", 32'(last_req), 32'(0));
    cycle(1, 0, 0);
    check("disc_req", 32'(last_req), 32'(1));
    check("disc_addr", 32'(last_addr), 32'h200);
    check("disc_cnt3", 32'(bus.q_count), 32'(0));

    // Redirect coinciding with a response while two entries are queued.
    lat = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.q_count == 2 && mem_pend && mem_cnt == 1) begin
        apply(0, 1, 16'h0300);
        found = 1;
      end else begin
        apply(0, 0, 0);
      end
    end
    check("rv_found", 32'(found), 32'(1));
    check("rv_noreq", 32'(last_req), 32'(0));
    cycle(0, 0, 0);
    check("rv_cnt", 32'(bus.q_count), 32'(0));
    check("rv_valid", 32'(bus.id_valid), 32'(0));
    check("rv_req", 32'(last_req), 32'(1));
    check("rv_addr", 32'(last_addr), 32'h300);

    // Address wrap.
    cycle(1, 1, 16'hFFFF);
    cycle(1, 0, 0);
    check("wrap_addr0", 32'(last_addr), 32'hFFFF);
    cycle(1, 0, 0);
    check("wrap_addr1", 32'(last_addr), 32'h0000);
    cycle(1, 0, 0);
    check("wrap_valid", 32'(bus.id_valid), 32'(1));
    check("wrap_op", 32'(bus.id_op), 32'(op_of(16'hFFFF)));
    check("wrap_pcn", 32'(bus.id_pc_next), 32'h0000);

    // Reset while waiting with three entries queued.
    lat = 3;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(0, 0, 0);
      found = (bus.q_count == 3) && mem_pend;
    end
    check("mr_found", 32'(found), 32'(1));
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_valid = 1'b0;
    mem_pend = 0;
    restart(RESET_PC);
    #1;
    check("mr_cnt", 32'(bus.q_count), 32'(0));
    check("mr_valid", 32'(bus.id_valid), 32'(0));
    check("mr_req", 32'(bus.imem_req), 32'(0));
    @(negedge clk);
    lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1;
    apply(1, 0, 0);
    check("mr_req0", 32'(last_req), 32'(1));
    check("mr_addr0", 32'(last_addr), 32'(RESET_PC));
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check("mr_v", 32'(bus.id_valid), 32'(1));
    check("mr_op", 32'(bus.id_op), 32'(op_of(RESET_PC)));

    // Random traffic against the stream model.
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 16'($urandom));
    end
    repeat (10) cycle(1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/poco_fetch_queue.md
Name: poco_fetch_queue

Overview:
- Parametrised instruction-fetch stage for the next POCO-R pipeline generation; replaces the fixed single-cycle fetch.
- Issues sequential requests to a variable-latency instruction memory and buffers the returned ops with their next-PC in a DEPTH-entry queue.
- Presents the ops to the decode stage with a valid/ready handshake, so decode can stall.
- Supports redirect (jump/branch taken in decode): flushes the queue and discards any in-flight memory response.

Parameters:
- XLEN, 16, PC/address width (word addressing, PC increments by 1)
- ILEN, 16, instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 0, fetch address after reset

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  one-cycle request pulse; imem_addr is valid in that cycle
- imem_addr  out  XLEN  fetch address
- imem_valid  in  1  response strobe; at least 1 cycle after its imem_req
- imem_data  in  ILEN  instruction data, sampled when imem_valid = 1
- redir_valid  in  1  redirect/flush request from decode
- redir_pc  in  XLEN  new fetch address
- id_valid  out  1  queue head is valid
- id_op  out  ILEN  head instruction
- id_pc_next  out  XLEN  head instruction address + 1
- id_ready  in  1  decode accepts the head this cycle
- q_count  out  clog2(DEPTH+1)  registered queue occupancy

Behaviour:
- Reset (async, rst_n = 0) forces:
  - fetch_pc = RESET_PC, queue empty, state = IDLE
  - imem_req = 0, id_valid = 0, q_count = 0
  - id_op and id_pc_next = 0
- At most one memory request is outstanding.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding.
  - DISCARD: a request is outstanding but its response must be dropped.
- Pop: occurs when id_valid && id_ready && !redir_valid.
- Push: occurs when state = WAIT && imem_valid && !redir_valid. The entry written is {imem_data, addr_of_req + 1}, where addr_of_req is the address latched at issue.
- Push and pop in the same cycle are legal; q_count is unchanged.
- Issue condition (combinational, may depend on id_ready):
  - !redir_valid, and
  - (state = IDLE) or (state = WAIT && imem_valid), and
  - q_count + push - pop < DEPTH.
- On issue:
  - imem_req = 1 and imem_addr = fetch_pc.
  - fetch_pc <= fetch_pc + 1, wrapping mod 2^XLEN.
  - Next state = WAIT.
- This gives a throughput of 1 op per cycle with a 1-cycle memory.
- Non-issue transitions:
  - WAIT with imem_valid and no issue -> IDLE.
  - DISCARD with imem_valid -> IDLE; the response is dropped and no request is issued in that cycle.
- Redirect has priority over everything in its cycle:
  - Queue is flushed (q_count <= 0, id_valid = 0 next cycle); no push or pop occurs.
  - fetch_pc <= redir_pc.
  - If state = WAIT and imem_valid = 0: next state = DISCARD.
  - If state = WAIT and imem_valid = 1: the response is dropped and next state = IDLE.
  - DISCARD stays DISCARD unless imem_valid = 1, then -> IDLE.
  - IDLE stays IDLE.
  - The first request to redir_pc issues no earlier than the cycle after the redirect.
- Queue full (q_count = DEPTH): no issue, imem_req stays 0.
- Queue empty: id_valid = 0; id_op and id_pc_next hold their last value.
- Combinational bypass from imem_data to id_op is not permitted; an op becomes visible the cycle after its push.
- imem_valid in IDLE is a protocol error: it is ignored. An assertion flags it in simulation.
- Reset mid-operation (any state) returns to reset values immediately. A response arriving after reset deassertion while in IDLE is ignored.

Decomposition:
- Shared package poco_pkg:
  - default XLEN and ILEN localparams
  - fetch FSM state enum (IDLE, WAIT, DISCARD)
  - queue-entry struct {op, pc_next}
- Sub-module poco_sync_fifo:
  - parametrised WIDTH and DEPTH; synchronous flush, push, pop, count
  - registered outputs, no write-through
- The fetch FSM, PC register and issue logic live in poco_fetch_queue.

Test Plan:
- Reset with RESET_PC = 0x0010, memory with 1-cycle latency, id_ready = 1 -> requests at 0x0010, 0x0011, 0x0012 on consecutive cycles; id_op streams 1 per cycle with id_pc_next = 0x0011, 0x0012, 0x0013.
- id_ready = 0, DEPTH = 4 -> q_count reaches 4 and imem_req stays 0. Raise id_ready -> one pop per cycle, and issue resumes in the same cycle as the first pop.
- 3-cycle memory latency, redirect to 0x0200 in the cycle after issue -> state DISCARD. The returning response is not pushed. Next request is 0x0200, issued the cycle after imem_valid. q_count = 0 throughout.
- Redirect with imem_valid = 1 in the same cycle, queue holding 2 entries -> both entries and the response are dropped; q_count = 0 next cycle; next request at redir_pc the following cycle.
- fetch_pc = 0xFFFF -> request at 0xFFFF, then 0x0000; the entry for 0xFFFF has id_pc_next = 0x0000.
- Assert rst_n = 0 while in WAIT with 3 entries queued -> q_count = 0, id_valid = 0, imem_req = 0 immediately. The late imem_valid after release is ignored. First request is to RESET_PC.
